// File: rtl/demux1in2_buf.sv
// 1-to-2 demux with a 2-entry FIFO per output; o_datN is registered, 1 cycle after accept.
// o_ready follows only the fullness of the FIFO i_control selects; a full FIFO stalls only its own route.

`ifndef MUX2IN1_WIDTH
`define MUX2IN1_WIDTH 8
`endif

module demux1in2_fifo2 #(
  parameter int WIDTH = `MUX2IN1_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             vld,
  output logic             full
);

  logic [1:0]       level;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push_ok;
  logic             pop_ok;

  assign vld     = (level != 2'd0);
  assign full    = (level == 2'd2);
  assign rd_dat  = head;
  assign push_ok = push && !full;
  assign pop_ok  = vld && pop_rdy;

  // Shift-style storage keeps the head word in a dedicated register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (level == 2'd0) head <= wr_dat;
          else               tail <= wr_dat;
          level <= level + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          level <= level - 2'd1;
        end
        2'b11: begin
          // Only reachable at level 1: the new word replaces the departing head.
          head <= wr_dat;
        end
        default: ;
      endcase
    end
  end

endmodule

module demux1in2_buf #(
  parameter int WIDTH = `MUX2IN1_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_valid,
  input  logic             i_control,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_dat0,
  output logic [WIDTH-1:0] o_dat1,
  output logic             o_valid0,
  output logic             o_valid1,
  input  logic             i_ready0,
  input  logic             i_ready1,
  output logic [7:0]       o_cnt0,
  output logic [7:0]       o_cnt1
);

  logic full0;
  logic full1;
  logic accept;
  logic push0;
  logic push1;

  assign o_ready = i_control ? !full1 : !full0;
  assign accept  = i_valid && o_ready;
  assign push0   = accept && !i_control;
  assign push1   = accept && i_control;

  demux1in2_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (push0),
    .wr_dat  (i_dat),
    .pop_rdy (i_ready0),
    .rd_dat  (o_dat0),
    .vld     (o_valid0),
    .full    (full0)
  );

  demux1in2_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (push1),
    .wr_dat  (i_dat),
    .pop_rdy (i_ready1),
    .rd_dat  (o_dat1),
    .vld     (o_valid1),
    .full    (full1)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt0 <= 8'd0;
      o_cnt1 <= 8'd0;
    end else begin
      if (push0) o_cnt0 <= o_cnt0 + 8'd1;
      if (push1) o_cnt1 <= o_cnt1 + 8'd1;
    end
  end

endmodule

// File: doc/demux1in2_buf.md
DEMUX1IN2_BUF -- requirements
Module: demux1in2_buf

Interface
REQ-001 Parameter WIDTH, default `MUX2IN1_WIDTH from defines.vh, data word width in bits.
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_dat  input  WIDTH  input data word.
REQ-005 i_valid  input  1  i_dat is valid this cycle.
REQ-006 i_control  input  1  route select: 0 to output 0, 1 to output 1; sampled with i_dat.
REQ-007 o_ready  output  1  block accepts the word offered this cycle.
REQ-008 o_dat0 / o_dat1  output  WIDTH  head word of output 0 / output 1 buffer.
REQ-009 o_valid0 / o_valid1  output  1  o_datN holds a valid word.
REQ-010 i_ready0 / i_ready1  input  1  downstream N takes o_datN this cycle.
REQ-011 o_cnt0 / o_cnt1  output  8  count of words accepted for output 0 / output 1.

Function
REQ-012 Each output SHALL own a 2-entry FIFO; level per FIFO 0, 1 or 2.
REQ-013 o_ready SHALL be combinational: o_ready = not full(FIFO selected by i_control); independent of i_valid and of i_readyN in the same cycle.
REQ-014 Accept event = i_valid and o_ready at a rising edge; the word SHALL be written to the FIFO selected by i_control.
REQ-015 Pop event on output N = o_validN and i_readyN at a rising edge; the head entry is removed.
REQ-016 o_validN SHALL equal (levelN != 0); o_datN SHALL be the oldest entry of FIFO N, registered.
REQ-017 Latency: a word accepted into an empty FIFO at edge k SHALL appear on o_datN with o_validN=1 immediately after edge k (1 cycle).
REQ-018 Per-output order SHALL be preserved; no word lost, duplicated or routed to the wrong output.
REQ-019 While o_validN=1 and i_readyN=0, o_datN and o_validN SHALL hold stable.
REQ-020 Push and pop on the same FIFO at the same edge: level 1 stays 1, with the new word as head; level 2 cannot accept (REQ-013, no bypass) and becomes 1.
REQ-021 Push into one FIFO and pop from the other at the same edge SHALL both complete independently.
REQ-022 Pop with level 0 SHALL not occur (o_validN=0); i_readyN is ignored when empty.
REQ-023 i_dat and i_control SHALL be ignored when i_valid=0; i_valid with o_ready=0 SHALL change no state.
REQ-024 o_cntN SHALL increment by 1 on each accept routed to N, wrapping 255 to 0; no saturation flag.
REQ-025 The design SHALL be free of combinational loops; o_ready SHALL depend only on i_control and FIFO levels.

Reset
REQ-026 i_rst_n=0 SHALL immediately, without a clock, force: all levels 0, o_valid0=o_valid1=0, o_dat0=o_dat1=0, o_cnt0=o_cnt1=0, FIFO pointers 0.
REQ-027 o_ready SHALL read 1 during and after reset (both FIFOs empty).
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; no accepts or pops take place while i_rst_n=0.
REQ-029 Operation resumes at the first rising edge after i_rst_n returns to 1.

Verification
REQ-030 Route: i_control=0, i_dat=8'hA5, i_valid=1 for one cycle, i_ready0=1 -> next cycle o_valid0=1, o_dat0=A5, o_valid1=0, o_cnt0=1; one cycle later o_valid0=0.
REQ-031 Full/back-pressure: i_ready1=0, push 11,22,33 to output 1 on consecutive cycles -> 11 and 22 accepted, o_ready=0 while 33 is offered, o_dat1=11 held; raise i_ready1 -> 11 then 22 emerge, 33 accepted after one slot frees, o_cnt1=3.
REQ-032 Independence: FIFO 1 full with i_control=0 -> o_ready=1 and the word enters FIFO 0.
REQ-033 Simultaneous: FIFO 0 at level 1, push 5 to output 0 and pop 0 at the same edge -> level stays 1, o_dat0=5.
REQ-034 Wrap: 256 accepts to output 0 -> o_cnt0 reads 0; the 257th accept -> 1.
REQ-035 Reset mid-operation: both FIFOs at level 2, drop i_rst_n between clock edges -> outputs immediately 0 and o_ready=1; after release, first popped word is the first word pushed after reset.
REQ-036 Random soak: $urandom data, control and readies for 10,000 cycles, checked against a per-output queue scoreboard -> zero mismatches; counters match accepts mod 256.
